num_digits_msg_display: RTL
===========================

NUM_DIGITS_MSG_DISPLAY -- requirements
Module: num_digits_msg_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed digits; legal range 4..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit stays enabled; legal range >= 2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 25, meaning full scan frames per blink half-period and per standby-dot step; legal range >= 1.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port S0..S3  input  1 each  drink-selection requests: CE01, CL02, CC05, CP10.
REQ-007 SHALL have port SR, SP, SN  input  1 each  sensor-fault flags: ERSR, ERSP, ERSN.
REQ-008 SHALL have port VL  input  1  money-validation fault: ERDI.
REQ-009 SHALL have port M  input  1  standby request.
REQ-010 SHALL have port SEG  output  8  segments, active-high; bit0=a … bit6=g, bit7=h (dp).
REQ-011 SHALL have port DIG  output  NUM_DIGITS  digit enables, active-low; bit0 = leftmost digit.

Function
REQ-012 SHALL run a scan counter 0..SCAN_DIV-1; on terminal count, digit index advances 0..NUM_DIGITS-1 and wraps to 0.
REQ-013 SHALL define a frame boundary as the cycle where the scan counter is at terminal count and the digit index is NUM_DIGITS-1.
REQ-014 SHALL sample the inputs and latch the message only at a frame boundary; an input change mid-frame SHALL take effect at the next frame boundary.
REQ-015 SHALL select the message by fixed priority: SR > SP > SN > VL > M (standby) > S0 > S1 > S2 > S3 > none (standby).
REQ-016 SHALL use these codes (gfedcba, hex): 0=3F, 1=06, 2=5B, 5=6D, C=39, E=79, L=38, P=73, r=50, S=6D, n=54, d=5E, I=30, blank=00.
REQ-017 SHALL spell messages CE01, CL02, CC05, CP10, ErSr, ErSP, ErSn, ErdI on digits 0..3, left-aligned; digits 4..NUM_DIGITS-1 blank.
REQ-018 SHALL drive h=0 for every message except standby.
REQ-019 SHALL run a frame counter 0..2*BLINK_FRAMES-1, incrementing at each frame boundary and wrapping.
REQ-020 SHALL display error messages (ErSr, ErSP, ErSn, ErdI) when frame counter < BLINK_FRAMES and blank them otherwise; DIG keeps scanning while blanked.
REQ-021 SHALL display selection messages steadily, without blinking.
REQ-022 SHALL show standby as blank segments with only h lit on digit dot_pos.
REQ-023 SHALL advance dot_pos by 1, modulo NUM_DIGITS, each time the frame counter wraps to 0 or reaches BLINK_FRAMES.
REQ-024 SHALL register SEG and DIG outputs, so they reflect the digit index of the previous cycle; exactly one DIG bit is low outside reset.
REQ-025 SHALL apply a new latched message first on the digit 0 slot of the frame that follows the boundary, so a frame never mixes two messages.

Reset
REQ-026 SHALL, while RST=1 at a clock edge: scan counter=0, digit index=0, frame counter=0, dot_pos=0, latched message=standby, SEG=8'h00, DIG=all ones.
REQ-027 SHALL apply RST asserted mid-operation on the next edge, with no partial-frame completion.
REQ-028 SHALL, on the first edge after RST deasserts, drive DIG bit0 low and SEG=8'h80 (standby dot on digit 0).

Verification (NUM_DIGITS=4, SCAN_DIV=2, BLINK_FRAMES=2)
REQ-029 SHALL cover: release reset, all inputs 0 -> DIG cycles 1110, 1110, 1101, 1101, 1011, …; SEG=80 only while DIG=1110 for frames 0-1, then dot moves to digit 1.
REQ-030 SHALL cover: S2=1 from reset -> after first boundary SEG per digit 39, 39, 3F, 6D steady every frame.
REQ-031 SHALL cover: S0=S3=SP=1 -> ErSP (79, 50, 6D, 73) for 2 frames, all-zero SEG for 2 frames, repeating.
REQ-032 SHALL cover: S1 raised while digit index=1 -> remainder of frame unchanged; CL02 (39, 38, 3F, 5B) from next digit-0 slot.
REQ-033 SHALL cover: M=1 with S0=1 -> standby dot; then VL=1 -> ErdI (79, 50, 5E, 30) blinking, overriding M.
REQ-034 SHALL cover: RST pulsed 1 cycle mid-frame while displaying ErSr -> next edge SEG=00, DIG=1111; following edge SEG=80, DIG=1110.

Source files
------------

// File: rtl/num_digits_msg_display.sv
// Multiplexed seven-segment message display for a vending machine front panel.
// Shows drink selections steadily, blinks error messages and walks a dot in standby.
module num_digits_msg_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S0,
    input  logic                  S1,
    input  logic                  S2,
    input  logic                  S3,
    input  logic                  SR,
    input  logic                  SP,
    input  logic                  SN,
    input  logic                  VL,
    input  logic                  M,
    output logic [7:0]            SEG,
    output logic [NUM_DIGITS-1:0] DIG
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = $clog2(2 * BLINK_FRAMES);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(2 * BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FRAME_HALF = FW'(BLINK_FRAMES);

    typedef enum logic [3:0] {
        MSG_STBY = 4'd0,
        MSG_CE01 = 4'd1,
        MSG_CL02 = 4'd2,
        MSG_CC05 = 4'd3,
        MSG_CP10 = 4'd4,
        MSG_ERSR = 4'd5,
        MSG_ERSP = 4'd6,
        MSG_ERSN = 4'd7,
        MSG_ERDI = 4'd8
    } msg_t;

    // Glyphs for digits 0..3, digit 0 in the top byte; dp always off.
    function automatic logic [31:0] msg_glyphs(input msg_t m);
        case (m)
            MSG_CE01: msg_glyphs = 32'h39_79_3F_06;
            MSG_CL02: msg_glyphs = 32'h39_38_3F_5B;
            MSG_CC05: msg_glyphs = 32'h39_39_3F_6D;
            MSG_CP10: msg_glyphs = 32'h39_73_06_3F;
            MSG_ERSR: msg_glyphs = 32'h79_50_6D_50;
            MSG_ERSP: msg_glyphs = 32'h79_50_6D_73;
            MSG_ERSN: msg_glyphs = 32'h79_50_6D_54;
            MSG_ERDI: msg_glyphs = 32'h79_50_5E_30;
            default:  msg_glyphs = 32'h00_00_00_00;
        endcase
    endfunction

    logic [SW-1:0]         scan_cnt_r;
    logic [IW-1:0]         dig_idx_r;
    logic [FW-1:0]         frame_cnt_r;
    logic [IW-1:0]         dot_pos_r;
    msg_t                  msg_r;
    logic [7:0]            seg_r;
    logic [NUM_DIGITS-1:0] dig_r;

    logic                  scan_tc_s;
    logic                  frame_tick_s;
    logic [FW-1:0]         frame_nxt_s;
    msg_t                  msg_sel_s;
    logic [31:0]           glyphs_s;
    logic                  is_err_s;
    logic [7:0]            seg_s;
    logic [NUM_DIGITS-1:0] dig_s;

    // Scan timing: digit terminal count, frame boundary and next frame count.
    always_comb begin
        scan_tc_s    = (scan_cnt_r == SCAN_LAST);
        frame_tick_s = scan_tc_s && (dig_idx_r == IDX_LAST);
        if (frame_cnt_r == FRAME_LAST) begin
            frame_nxt_s = {FW{1'b0}};
        end else begin
            frame_nxt_s = frame_cnt_r + FW'(1);
        end
    end

    // Fixed-priority message selection from the live inputs.
    always_comb begin
        msg_sel_s = MSG_STBY;
        if (SR) begin
            msg_sel_s = MSG_ERSR;
        end else if (SP) begin
            msg_sel_s = MSG_ERSP;
        end else if (SN) begin
            msg_sel_s = MSG_ERSN;
        end else if (VL) begin
            msg_sel_s = MSG_ERDI;
        end else if (M) begin
            msg_sel_s = MSG_STBY;
        end else if (S0) begin
            msg_sel_s = MSG_CE01;
        end else if (S1) begin
            msg_sel_s = MSG_CL02;
        end else if (S2) begin
            msg_sel_s = MSG_CC05;
        end else if (S3) begin
            msg_sel_s = MSG_CP10;
        end else begin
            msg_sel_s = MSG_STBY;
        end
    end

    // Segment and digit-enable pattern for the digit currently being scanned.
    always_comb begin
        glyphs_s = msg_glyphs(msg_r);
        is_err_s = (msg_r == MSG_ERSR) || (msg_r == MSG_ERSP) ||
                   (msg_r == MSG_ERSN) || (msg_r == MSG_ERDI);
        seg_s    = 8'h00;
        if (msg_r == MSG_STBY) begin
            seg_s = (dot_pos_r == dig_idx_r) ? 8'h80 : 8'h00;
        end else if (is_err_s && (frame_cnt_r >= FRAME_HALF)) begin
            seg_s = 8'h00;
        end else begin
            case (dig_idx_r)
                IW'(0):  seg_s = glyphs_s[31:24];
                IW'(1):  seg_s = glyphs_s[23:16];
                IW'(2):  seg_s = glyphs_s[15:8];
                IW'(3):  seg_s = glyphs_s[7:0];
                default: seg_s = 8'h00;
            endcase
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_s[i] = (dig_idx_r != IW'(i));
        end
    end

    // Scan, frame, dot and message state; the message only changes on a frame boundary.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt_r  <= {SW{1'b0}};
            dig_idx_r   <= {IW{1'b0}};
            frame_cnt_r <= {FW{1'b0}};
            dot_pos_r   <= {IW{1'b0}};
            msg_r       <= MSG_STBY;
        end else begin
            scan_cnt_r <= scan_tc_s ? {SW{1'b0}} : scan_cnt_r + SW'(1);
            if (scan_tc_s) begin
                dig_idx_r <= (dig_idx_r == IDX_LAST) ? {IW{1'b0}} : dig_idx_r + IW'(1);
            end
            if (frame_tick_s) begin
                msg_r       <= msg_sel_s;
                frame_cnt_r <= frame_nxt_s;
                if ((frame_nxt_s == {FW{1'b0}}) || (frame_nxt_s == FRAME_HALF)) begin
                    dot_pos_r <= (dot_pos_r == IDX_LAST) ? {IW{1'b0}} : dot_pos_r + IW'(1);
                end
            end
        end
    end

    // Registered display outputs, one cycle behind the scan index.
    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_r <= 8'h00;
            dig_r <= {NUM_DIGITS{1'b1}};
        end else begin
            seg_r <= seg_s;
            dig_r <= dig_s;
        end
    end

    assign SEG = seg_r;
    assign DIG = dig_r;

endmodule
